// File: rtl/and32_pkg.sv
// Shared constants and helpers for the and32 block.
package and32_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  // Bits needed to count from 0 to w inclusive.
  function automatic int unsigned ones_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage : and32_pkg

// File: rtl/and32_if.sv
// Operand/result bundle for and32: master drives operands, slave returns results.
interface and32_if
  import and32_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  localparam int unsigned OW = ones_w(WIDTH);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic [WIDTH-1:0] R;
  logic             out_valid;
  logic             Z;
  logic             N;
  logic [OW-1:0]    ONES;

  modport master (
    output A, B, in_valid,
    input  R, out_valid, Z, N, ONES
  );

  modport slave (
    input  A, B, in_valid,
    output R, out_valid, Z, N, ONES
  );

endinterface : and32_if

// File: rtl/and32_popcnt.sv
// Combinational population count as a balanced pairwise adder tree.
module and32_popcnt
  import and32_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned OW    = ones_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [OW-1:0]    o_count
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned NP     = 1 << LEVELS;

  // In-place reduction: each level halves the live node count; node i reads
  // nodes 2i and 2i+1, which are never overwritten before they are read.
  always_comb begin : tree
    logic [OW-1:0] w_node [NP];
    w_node = '{default: '0};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_node[i] = OW'(i_a[i]);
    end
    for (int unsigned l = 0; l < LEVELS; l++) begin
      for (int unsigned i = 0; i < (NP >> (l + 1)); i++) begin
        w_node[i] = w_node[2*i] + w_node[2*i+1];
      end
    end
    o_count = w_node[0];
  end

endmodule : and32_popcnt

// File: rtl/and32.sv
// and32: registered bitwise AND of two operands with zero/MSB/popcount flags.
// Flag and popcount logic is built only when AND32_FLAGS_EN is defined;
// otherwise Z, N and ONES are tied low and the port list is unchanged.
module and32
  import and32_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  and32_if.slave bus
);

  localparam int unsigned OW = ones_w(WIDTH);

  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] r_r;
  logic             r_out_valid;

  assign w_r_next = bus.A & bus.B;

  // Result register: loads only on qualified operands, pulses out_valid per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_r <= w_r_next;
      end
    end
  end

  assign bus.R         = r_r;
  assign bus.out_valid = r_out_valid;

`ifdef AND32_FLAGS_EN
  logic [OW-1:0] w_ones_next;
  logic [OW-1:0] r_ones;
  logic          r_z;
  logic          r_n;

  and32_popcnt #(
    .WIDTH (WIDTH)
  ) u_popcnt (
    .i_a     (w_r_next),
    .o_count (w_ones_next)
  );

  // Flags are computed from the next result so they update with R on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z    <= 1'b1;
      r_n    <= 1'b0;
      r_ones <= '0;
    end else if (bus.in_valid) begin
      r_z    <= ~|w_r_next;
      r_n    <= w_r_next[WIDTH-1];
      r_ones <= w_ones_next;
    end
  end

  assign bus.Z    = r_z;
  assign bus.N    = r_n;
  assign bus.ONES = r_ones;
`else
  assign bus.Z    = 1'b0;
  assign bus.N    = 1'b0;
  assign bus.ONES = OW'(0);
`endif

endmodule : and32

// File: tb/tb_and32.sv
// Directed self-checking bench for and32 (WIDTH=32). Flag expectations follow
// the AND32_FLAGS_EN build setting.
module tb_and32;

  localparam int unsigned WIDTH = 32;
`ifdef AND32_FLAGS_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  and32_if #(.WIDTH(WIDTH)) bus ();

  and32 #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compare all outputs; flag expectations collapse to 0 when flags are not built.
  task automatic check_out(input string tag, input logic [31:0] r, input logic ov,
                           input logic z, input logic n, input int ones);
    check({tag, ".R"},         64'(bus.R),         64'(r));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    check({tag, ".Z"},         64'(bus.Z),         FLG ? 64'(z) : 64'(0));
    check({tag, ".N"},         64'(bus.N),         FLG ? 64'(n) : 64'(0));
    check({tag, ".ONES"},      64'(bus.ONES),      FLG ? 64'(ones) : 64'(0));
  endtask

  // Present operands at the falling edge, sample just after the capturing edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic v);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.in_valid = 1'b0;

    #23;
    check_out("reset", 32'h0, 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(32'hFFFF_FFFF, 32'h40A0_0400, 1'b1);
    check_out("mask", 32'h40A0_0400, 1'b1, 1'b0, 1'b0, 4);

    apply(32'h2222_0225, 32'hC242_0423, 1'b1);
    check_out("mixed", 32'h0202_0021, 1'b1, 1'b0, 1'b0, 4);

    apply(32'h0000_0000, 32'hDEAD_BEEF, 1'b1);
    check_out("zero_op", 32'h0, 1'b1, 1'b1, 1'b0, 0);

    // Idle cycles with unknown operands must leave everything held.
    for (int k = 0; k < 3; k++) begin
      apply('x, 32'hFFFF_FFFF, 1'b0);
      check_out($sformatf("hold%0d", k), 32'h0, 1'b0, 1'b1, 1'b0, 0);
    end

    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    check_out("stream0", 32'hF000_F000, 1'b1, 1'b0, 1'b1, 8);
    apply(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    check_out("stream1", 32'h0204_0608, 1'b1, 1'b0, 1'b0, 5);
    apply(32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
    check_out("stream2", 32'h8000_0001, 1'b1, 1'b0, 1'b1, 2);
    apply(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    check_out("stream3", 32'h0, 1'b1, 1'b1, 1'b0, 0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_out("stream_end", 32'h0, 1'b0, 1'b1, 1'b0, 0);

    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_out("all_ones", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32);

    // Reset between edges must clear outputs without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 32'h0, 1'b0, 1'b1, 1'b0, 0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_out("post_rst_idle", 32'h0, 1'b0, 1'b1, 1'b0, 0);

    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_out("post_rst_ones", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32);

    apply(32'h0000_0001, 32'h0000_0003, 1'b1);
    check_out("lsb", 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_and32
